// File: rtl/morse_modport_if.sv
// Keying-side bundle for the Morse decoder: symbol/space pulses in, decoded character out.
interface morse_modport_if;
    logic       dot_inp;
    logic       dash_inp;
    logic       char_space_inp;
    logic       word_space_inp;
    logic [7:0] sout;

    modport master (
        output dot_inp,
        output dash_inp,
        output char_space_inp,
        output word_space_inp,
        input  sout
    );

    modport slave (
        input  dot_inp,
        input  dash_inp,
        input  char_space_inp,
        input  word_space_inp,
        output sout
    );
endinterface

// File: rtl/morse_modport.sv
// Morse symbol decoder: collects up to six dot/dash symbols and emits ASCII on char/word space.
// Optional build macro MORSE_PUNCT_EN adds the six-symbol punctuation decodes plus '/' and '='.
module morse_modport (
    input  logic            clk,
    input  logic            rst,
    morse_modport_if.slave  bus
);

    logic [2:0] cnt_q,  cnt_d;
    logic [5:0] bits_q, bits_d;
    logic       ovf_q,  ovf_d;
    logic [7:0] sout_q, sout_d;
    logic [3:0] req;

    // Key is {symbol count, symbols}; first symbol sits in the MSB of the used field.
    function automatic logic [7:0] decode(input logic [2:0] cnt, input logic [5:0] bits);
        logic [7:0] ch;
        ch = 8'h3F;
        case ({cnt, bits})
            {3'd1, 6'b000000}: ch = "E";
            {3'd1, 6'b000001}: ch = "T";
            {3'd2, 6'b000000}: ch = "I";
            {3'd2, 6'b000001}: ch = "A";
            {3'd2, 6'b000010}: ch = "N";
            {3'd2, 6'b000011}: ch = "M";
            {3'd3, 6'b000000}: ch = "S";
            {3'd3, 6'b000001}: ch = "U";
            {3'd3, 6'b000010}: ch = "R";
            {3'd3, 6'b000011}: ch = "W";
            {3'd3, 6'b000100}: ch = "D";
            {3'd3, 6'b000101}: ch = "K";
            {3'd3, 6'b000110}: ch = "G";
            {3'd3, 6'b000111}: ch = "O";
            {3'd4, 6'b000000}: ch = "H";
            {3'd4, 6'b000001}: ch = "V";
            {3'd4, 6'b000010}: ch = "F";
            {3'd4, 6'b000100}: ch = "L";
            {3'd4, 6'b000110}: ch = "P";
            {3'd4, 6'b000111}: ch = "J";
            {3'd4, 6'b001000}: ch = "B";
            {3'd4, 6'b001001}: ch = "X";
            {3'd4, 6'b001010}: ch = "C";
            {3'd4, 6'b001011}: ch = "Y";
            {3'd4, 6'b001100}: ch = "Z";
            {3'd4, 6'b001101}: ch = "Q";
            {3'd5, 6'b011111}: ch = "0";
            {3'd5, 6'b001111}: ch = "1";
            {3'd5, 6'b000111}: ch = "2";
            {3'd5, 6'b000011}: ch = "3";
            {3'd5, 6'b000001}: ch = "4";
            {3'd5, 6'b000000}: ch = "5";
            {3'd5, 6'b010000}: ch = "6";
            {3'd5, 6'b011000}: ch = "7";
            {3'd5, 6'b011100}: ch = "8";
            {3'd5, 6'b011110}: ch = "9";
`ifdef MORSE_PUNCT_EN
            {3'd5, 6'b010010}: ch = "/";
            {3'd5, 6'b010001}: ch = "=";
            {3'd6, 6'b010101}: ch = ".";
            {3'd6, 6'b110011}: ch = ",";
            {3'd6, 6'b001100}: ch = "?";
`endif
            default:           ch = 8'h3F;
        endcase
        return ch;
    endfunction

    assign req = {bus.dot_inp, bus.dash_inp, bus.char_space_inp, bus.word_space_inp};

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            bits_q <= '0;
            ovf_q  <= 1'b0;
            sout_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            bits_q <= bits_d;
            ovf_q  <= ovf_d;
            sout_q <= sout_d;
        end
    end

    // Cycles with zero or several inputs high leave all state untouched.
    always_comb begin
        cnt_d  = cnt_q;
        bits_d = bits_q;
        ovf_d  = ovf_q;
        sout_d = sout_q;
        if ($onehot(req)) begin
            if (bus.dot_inp || bus.dash_inp) begin
                if (cnt_q < 3'd6) begin
                    bits_d = {bits_q[4:0], bus.dash_inp};
                    cnt_d  = cnt_q + 3'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (bus.char_space_inp) begin
                if (cnt_q != 3'd0 || ovf_q) begin
                    sout_d = ovf_q ? 8'h3F : decode(cnt_q, bits_q);
                    cnt_d  = '0;
                    bits_d = '0;
                    ovf_d  = 1'b0;
                end
            end else begin
                sout_d = 8'h20;
                cnt_d  = '0;
                bits_d = '0;
                ovf_d  = 1'b0;
            end
        end
    end

    assign bus.sout = sout_q;

endmodule

// File: tb/tb_morse_modport.sv
// Directed self-checking bench for morse_modport with hand-computed ASCII expectations.
module tb_morse_modport;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [7:0] last_exp;

    morse_modport_if bus ();

    morse_modport dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int unsigned {P_DOT, P_DASH, P_CS, P_WS, P_BOTH, P_IDLE} pulse_t;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Drive for exactly one rising edge; returns at the following falling edge.
    task automatic pulse(input pulse_t p);
        @(negedge clk);
        bus.dot_inp        = (p == P_DOT)  || (p == P_BOTH);
        bus.dash_inp       = (p == P_DASH) || (p == P_BOTH);
        bus.char_space_inp = (p == P_CS);
        bus.word_space_inp = (p == P_WS);
        @(negedge clk);
        bus.dot_inp        = 1'b0;
        bus.dash_inp       = 1'b0;
        bus.char_space_inp = 1'b0;
        bus.word_space_inp = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_char(input string tag, input int n, input logic [5:0] sym, input logic [7:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            pulse(sym[i] ? P_DASH : P_DOT);
            if (i == n - 1) check({tag, "_hold"}, bus.sout, last_exp);
        end
        pulse(P_CS);
        check(tag, bus.sout, exp);
        last_exp = exp;
        idle(3);
        check({tag, "_keep"}, bus.sout, exp);
    endtask

    initial begin
        logic [7:0] punct_exp;
        logic [7:0] slash_exp;
        n_checks = 0;
        n_errors = 0;
        last_exp = 8'h00;
        rst = 1'b0;
        bus.dot_inp        = 1'b0;
        bus.dash_inp       = 1'b0;
        bus.char_space_inp = 1'b0;
        bus.word_space_inp = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.dot_inp = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("reset_hold", bus.sout, 8'h00);
        end
        @(negedge clk);
        bus.dot_inp = 1'b0;
        rst = 1'b1;
        pulse(P_CS);
        check("empty_cs", bus.sout, 8'h00);
        idle(3);

        send_char("A", 2, 6'b000001, 8'h41);
        send_char("zero", 5, 6'b011111, 8'h30);
        send_char("four", 5, 6'b000001, 8'h34);

        pulse(P_DOT);
        check("pend_hold", bus.sout, last_exp);
        pulse(P_DASH);
        pulse(P_WS);
        for (int i = 0; i < 8; i++) begin
            check("word_space", bus.sout, 8'h20);
            @(negedge clk);
        end
        check("word_space_T8", bus.sout, 8'h20);
        last_exp = 8'h20;
        send_char("E_after_ws", 1, 6'b000000, 8'h45);

        for (int i = 0; i < 7; i++) pulse(P_DOT);
        check("ovf_hold", bus.sout, 8'h45);
        pulse(P_CS);
        check("overflow", bus.sout, 8'h3F);
        last_exp = 8'h3F;
        idle(3);
        send_char("T_after_ovf", 1, 6'b000001, 8'h54);

        pulse(P_WS);
        idle(7);
        check("ws2", bus.sout, 8'h20);
        last_exp = 8'h20;
        pulse(P_BOTH);
        check("illegal_ignored", bus.sout, 8'h20);
        send_char("T_after_illegal", 1, 6'b000001, 8'h54);

`ifdef MORSE_PUNCT_EN
        punct_exp = 8'h2E;
        slash_exp = 8'h2F;
`else
        punct_exp = 8'h3F;
        slash_exp = 8'h3F;
`endif
        send_char("period", 6, 6'b010101, punct_exp);
        send_char("Z", 4, 6'b001100, 8'h5A);
        send_char("slash", 5, 6'b010010, slash_exp);
        send_char("undef4", 4, 6'b000011, 8'h3F);
        send_char("O", 3, 6'b000111, 8'h4F);
        send_char("nine", 5, 6'b011110, 8'h39);

        @(negedge clk);
        bus.dash_inp = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid", bus.sout, 8'h00);
        @(negedge clk);
        bus.dash_inp = 1'b0;
        rst = 1'b1;
        pulse(P_CS);
        check("reset_cleared_buf", bus.sout, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
